// File: rtl/seq_det_pkg.sv
// Shared types and helpers for param_sequence_detector.
package seq_det_pkg;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  localparam int PAT_W_MAX = 32;

  // Width needed to count 0..pat_w valid bits.
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_shift_window.sv
// PAT_W-bit serial history plus saturating fill counter.
// hist is the look-ahead window: the stored bits with din appended, i.e. the
// history as it will read after a shift this cycle. Only PAT_W-1 bits need
// storing for that. last=1 means a shift now completes (or keeps) a full window.
module seq_shift_window
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic             din,
  input  logic             flush,
  output logic [PAT_W-1:0] hist,
  output logic             full,
  output logic             last
);

  localparam int FW = fill_w(PAT_W);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W);
  localparam logic [FW-1:0] FILL_LAST = FW'(PAT_W - 1);

  logic [PAT_W-2:0] hist_q;
  logic [FW-1:0]    fill;

  assign hist = {hist_q, din};
  assign full = (fill == FILL_MAX);
  assign last = (fill >= FILL_LAST);

  // History shift and saturating fill count; flush beats shift.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_q <= '0;
      fill   <= '0;
    end else if (flush) begin
      hist_q <= '0;
      fill   <= '0;
    end else if (shift) begin
      hist_q <= hist[PAT_W-2:0];
      if (fill != FILL_MAX) fill <= fill + FW'(1);
    end
  end

endmodule

// File: rtl/param_sequence_detector.sv
// Runtime-loadable serial pattern detector with overlap / non-overlap modes
// and a saturating match counter.
// Optional feature macro: SEQ_DET_MASK_EN adds mask_in (per-bit compare enable).
module param_sequence_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0] mask_in,
`endif
  input  logic             overlap_en,
  input  logic             cnt_clr,
  input  logic             x_valid,
  input  logic             x,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] next_hist;
  logic             win_full;
  logic             win_last;
  logic             shift;
  logic             match;
  logic             flush;
  state_t           state_q, state_d;

`ifdef SEQ_DET_MASK_EN
  logic [PAT_W-1:0] mask_q;

  // Pattern and mask registers, loaded together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pat_q  <= '0;
      mask_q <= '1;
    end else if (pat_load) begin
      pat_q  <= pat_in;
      mask_q <= mask_in;
    end
  end
`else
  localparam logic [PAT_W-1:0] mask_q = '1;

  // Pattern register.
  always_ff @(posedge clk) begin
    if (!reset)        pat_q <= '0;
    else if (pat_load) pat_q <= pat_in;
  end
`endif

  // A load discards any bit arriving in the same cycle.
  assign shift = x_valid && !pat_load;
  assign match = shift && win_last && (((next_hist ^ pat_q) & mask_q) == '0);
  assign flush = pat_load || (match && !overlap_en);

  seq_shift_window #(.PAT_W(PAT_W)) u_win (
    .clk   (clk),
    .reset (reset),
    .shift (shift),
    .din   (x),
    .flush (flush),
    .hist  (next_hist),
    .full  (win_full),
    .last  (win_last)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_FILL;
    else        state_q <= state_d;
  end

  // Next state: armed once the window is full, back to fill on any flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL:  if (!flush && shift && win_last) state_d = ST_ARMED;
      ST_ARMED: if (flush || !win_full)          state_d = ST_FILL;
      default:                                   state_d = ST_FILL;
    endcase
  end

  // Registered match pulse and saturating counter; clear beats increment.
  always_ff @(posedge clk) begin
    if (!reset) begin
      y         <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      y <= match;
      if (cnt_clr) begin
        match_cnt <= '0;
        cnt_sat   <= 1'b0;
      end else if (match) begin
        if (match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
        if (match_cnt >= CNT_W'({CNT_W{1'b1}} - 1'b1)) cnt_sat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_param_sequence_detector.sv
// Self-checking bench: directed test-plan scenarios then random traffic,
// compared against a queue-based reference model.
module tb_param_sequence_detector;

  localparam int P = 4;
  localparam int C = 2;
  localparam int CMAX = (1 << C) - 1;

  logic         clk = 1'b0;
  logic         reset, pat_load, overlap_en, cnt_clr, x_valid, x;
  logic [P-1:0] pat_in, mask_in;
  logic         y;
  logic [C-1:0] match_cnt;
  logic         cnt_sat;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  bit       q[$];
  bit [P-1:0] m_pat, m_mask;
  bit       m_y, m_sat;
  int       m_cnt;

  always #5 clk = ~clk;

  param_sequence_detector #(.PAT_W(P), .CNT_W(C)) dut (
    .clk        (clk),
    .reset      (reset),
    .pat_load   (pat_load),
    .pat_in     (pat_in),
`ifdef SEQ_DET_MASK_EN
    .mask_in    (mask_in),
`endif
    .overlap_en (overlap_en),
    .cnt_clr    (cnt_clr),
    .x_valid    (x_valid),
    .x          (x),
    .y          (y),
    .match_cnt  (match_cnt),
    .cnt_sat    (cnt_sat)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: keep the valid bits seen since the last flush (at most P);
  // a match is a full window agreeing with the pattern on every enabled bit.
  task automatic model(input bit r, pl, input bit [P-1:0] pi, mi,
                       input bit ov, clr, xv, xb);
    bit hit;
    hit = 0;
    if (!r) begin
      q.delete(); m_pat = '0; m_mask = '1; m_y = 0; m_cnt = 0; m_sat = 0;
      return;
    end
    if (pl) begin
      m_pat = pi;
`ifdef SEQ_DET_MASK_EN
      m_mask = mi;
`else
      m_mask = '1;
`endif
      q.delete();
    end else if (xv) begin
      q.push_back(xb);
      if (q.size() > P) void'(q.pop_front());
      if (q.size() == P) begin
        hit = 1;
        for (int i = 0; i < P; i++)
          if (m_mask[P-1-i] && (q[i] != m_pat[P-1-i])) hit = 0;
        if (hit && !ov) q.delete();
      end
    end
    m_y = hit;
    if (clr) begin
      m_cnt = 0; m_sat = 0;
    end else if (hit) begin
      if (m_cnt < CMAX) m_cnt++;
      if (m_cnt == CMAX) m_sat = 1;
    end
  endtask

  task automatic step(input bit r, pl, input bit [P-1:0] pi, mi,
                      input bit ov, clr, xv, xb);
    reset = r; pat_load = pl; pat_in = pi; mask_in = mi;
    overlap_en = ov; cnt_clr = clr; x_valid = xv; x = xb;
    @(posedge clk);
    model(r, pl, pi, mi, ov, clr, xv, xb);
    #1;
    chk("y", y, m_y);
    chk("match_cnt", match_cnt, m_cnt);
    chk("cnt_sat", cnt_sat, m_sat);
  endtask

  // reset, then load a pattern (mask all-ones) with the given overlap mode
  task automatic setup(input bit [P-1:0] pat, input bit ov);
    step(0, 0, '0, '1, ov, 0, 0, 0);
    step(1, 1, pat, '1, ov, 0, 0, 0);
  endtask

  task automatic stream(input bit [15:0] bits, input int n, input bit ov);
    for (int i = n - 1; i >= 0; i--) step(1, 0, '0, '1, ov, 0, 1, bits[i]);
  endtask

  initial begin
    // reset state
    step(0, 0, '0, '1, 0, 0, 0, 0);
    step(0, 0, '0, '1, 0, 0, 1, 1);
    chk("rst_y", y, 0);
    chk("rst_cnt", match_cnt, 0);

    // overlap, 1011011 -> two pulses
    setup(4'b1011, 1);
    stream(16'b1011011, 7, 1);
    chk("tp_ovl_cnt", match_cnt, 2);

    // non-overlap, same stream -> one pulse
    setup(4'b1011, 0);
    stream(16'b1011011, 7, 0);
    chk("tp_novl_cnt1", match_cnt, 1);
    setup(4'b1011, 0);
    stream(16'b10111011, 8, 0);
    chk("tp_novl_cnt2", match_cnt, 2);

    // x_valid gaps between bits 2 and 3
    setup(4'b1011, 1);
    stream(16'b10, 2, 1);
    repeat (3) step(1, 0, '0, '1, 1, 0, 0, 1);
    step(1, 0, '0, '1, 1, 0, 1, 1);
    chk("tp_gap_nopulse", y, 0);
    step(1, 0, '0, '1, 1, 0, 1, 1);
    chk("tp_gap_pulse", y, 1);
    step(1, 0, '0, '1, 1, 0, 0, 0);
    chk("tp_gap_once", y, 0);

    // pat_load mid-stream discards the same-cycle bit
    setup(4'b1011, 1);
    stream(16'b101, 3, 1);
    step(1, 1, 4'b0110, '1, 1, 0, 1, 1);
    chk("tp_load_nopulse", y, 0);
    stream(16'b0110, 4, 1);
    chk("tp_load_pulse", y, 1);

    // saturation with period-1 pattern, then clear
    setup(4'b1111, 1);
    stream(16'hFF, 8, 1);
    chk("tp_sat_cnt", match_cnt, 3);
    chk("tp_sat_flag", cnt_sat, 1);
    step(1, 0, '0, '1, 1, 1, 0, 0);
    chk("tp_clr_cnt", match_cnt, 0);
    chk("tp_clr_flag", cnt_sat, 0);

    // reset after bit 3 of 1011
    setup(4'b1011, 1);
    stream(16'b101, 3, 1);
    step(0, 0, '0, '1, 1, 0, 1, 1);
    chk("tp_midrst_y", y, 0);

`ifdef SEQ_DET_MASK_EN
    step(0, 0, '0, '1, 1, 0, 0, 0);
    step(1, 1, 4'b1011, 4'b1001, 1, 0, 0, 0);
    stream(16'b1101, 4, 1);
    chk("tp_mask_pulse", y, 1);
`endif

    // random traffic
    step(0, 0, '0, '1, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      bit r, pl, ov, clr, xv, xb;
      bit [P-1:0] pi, mi;
      r   = ($urandom_range(99) >= 1);
      pl  = ($urandom_range(99) < 4);
      pi  = ($urandom_range(3) == 0) ? 4'b1111 : P'($urandom);
      mi  = ($urandom_range(1) == 0) ? 4'b1111 : P'($urandom);
      ov  = ($urandom_range(3) != 0);
      clr = ($urandom_range(99) < 3);
      xv  = ($urandom_range(9) < 8);
      xb  = (pi == 4'b1111) ? ($urandom_range(7) != 0) : 1'($urandom);
      step(r, pl, pi, mi, ov, clr, xv, xb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
